io_input_unit: RTL and testbench
================================

# io_input_unit

Memory-mapped input peripheral that answers CPU loads from board switches and push-buttons. It is the read-side counterpart of the LSU's LED output registers and sits beside the LSU on the same `i_lsu_addr` / `i_lsu_wren` / `i_st_data` bus. Raw pins are synchronized and, for keys, debounced. Press events are latched into a write-1-to-clear edge register and a press counter. Registered load data is returned with the same one-cycle latency as LSU loads; the LSU top selects `o_io_ld_data` whenever `o_io_hit` is 1.

## Interface
Parameters:
- `SW_W`, default 18: number of slide switches.
- `KEY_W`, default 4: number of push-buttons. Must be 1..32.
- `DEBOUNCE_CYCLES`, default 500000: consecutive stable cycles required to accept a key change. Must be ≥ 2. Benches use 4.

Ports:
- `i_clk`, in, 1: clock.
- `i_rst`, in, 1: reset, asynchronous, active-high.
- `i_io_sw`, in, `SW_W`: raw switches, active-high, asynchronous to `i_clk`.
- `i_io_key`, in, `KEY_W`: raw buttons, active-low (0 = pressed), asynchronous to `i_clk`.
- `i_lsu_addr`, in, 32: byte address from the LSU.
- `i_lsu_wren`, in, 1: store strobe.
- `i_st_data`, in, 32: store data.
- `o_io_ld_data`, out, 32: registered load data.
- `o_io_hit`, out, 1: registered flag, 1 when the previous cycle's address decoded to this block.

## Operation
Address decode uses `i_lsu_addr[31:2]`; byte offset is ignored.
- `0x1C10`–`0x1C13` SW: read-only. Returns synchronized switches, zero-extended.
- `0x1C14`–`0x1C17` KEY: read-only. Returns debounced key state, active-high (1 = pressed), zero-extended.
- `0x1C18`–`0x1C1B` EDGE: read; write-1-to-clear. Bit k is set on each debounced press of key k.
- `0x1C1C`–`0x1C1F` COUNT: read. 32-bit count of debounced presses of key 0; wraps `0xFFFFFFFF` → 0. Any write clears it.
- All other addresses: `o_io_ld_data` = 0 and `o_io_hit` = 0 next cycle. Writes have no effect.
- Writes to SW or KEY are ignored.

Synchronization:
- A 2-flop synchronizer on every switch and key bit.
- Reset values: switch syncs 0; key syncs all 1 (released).
- Keys are inverted after synchronization, so pressed = 1 internally.

Debounce, per key, with state `stable` (reset 0) and a counter (reset 0, width `$clog2(DEBOUNCE_CYCLES)`):
- synced == stable → counter cleared to 0.
- synced != stable and counter < `DEBOUNCE_CYCLES-1` → counter increments.
- synced != stable and counter == `DEBOUNCE_CYCLES-1` → stable <= synced and counter cleared. This is the "accept" clock.
- A glitch shorter than `DEBOUNCE_CYCLES` synced cycles causes no change.

Event logic:
- An accept with a 0→1 transition of key k sets EDGE[k] in that same clock.
- An accept with a 0→1 transition of key 0 also increments COUNT in that same clock.
- A release never sets EDGE or changes COUNT.

Simultaneous events:
- EDGE clear and set on the same bit in the same clock: set wins, so no event is lost.
- COUNT write and key-0 press in the same clock: COUNT becomes 1.
- A read in the same cycle as a write returns the pre-write value.

## Timing
- Load latency is 1 cycle. Data for the address presented at edge n appears after edge n and is valid throughout cycle n+1, with no stall or handshake.
- Switch pin → SW readable: 2 cycles of synchronizer latency, plus 1 cycle of read latency.
- Key pin held → KEY/EDGE/COUNT update: 2 synchronizer cycles + `DEBOUNCE_CYCLES` cycles.
- Reset values: `o_io_ld_data` = 0, `o_io_hit` = 0; synchronizers and `stable` as above; debounce counters, EDGE and COUNT all 0.
- Reset mid-debounce discards partial counts. A key still held after reset is re-debounced from zero and produces a fresh EDGE event.

## Test plan
All scenarios use `DEBOUNCE_CYCLES` = 4.
- **Switch read:** `i_io_sw`=`18'h2A5A5`, wait 3 cycles, load `0x1C12` → next cycle `o_io_ld_data`=`32'h0002A5A5`, `o_io_hit`=1.
- **Debounce:**
  - `i_io_key[0]`=0 for 3 cycles, then 1 → KEY=0, EDGE=0, COUNT=0.
  - Hold 0 for 10 cycles → KEY=`0x1`, EDGE=`0x1`, COUNT=1.
  - Release and wait 10 cycles → KEY=0, EDGE still `0x1`.
- **W1C race:**
  - Store `0x1` to `0x1C18` → EDGE=0.
  - Time a key-1 accept on the same clock as a store of `0x2` to `0x1C18` → EDGE=`0x2`.
- **Counter:**
  - Five separate key-0 presses → COUNT=5.
  - Store to `0x1C1C` on the same clock as a press accept → COUNT=1.
- **Unmapped / read-only:**
  - Load `0x1C00` → `o_io_ld_data`=0, `o_io_hit`=0.
  - Store `0xFFFFFFFF` to `0x1C10`, then load it → still returns the switch value.
- **Reset mid-operation:**
  - Assert `i_rst` two cycles into a debounce with the key held → all outputs 0 immediately.
  - After release, with the key still held, KEY=`0x1` after 6 more cycles and EDGE=`0x1`.

Source files
------------

// File: rtl/io_input_unit.sv
// io_input_unit: memory-mapped switch/key input block beside the LSU.
// Synchronizes raw pins, debounces keys, latches press events (W1C edge
// register and key-0 press counter) and returns registered load data.
module io_input_unit #(
   parameter int SW_W            = 18,
   parameter int KEY_W           = 4,
   parameter int DEBOUNCE_CYCLES = 500000
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic [SW_W-1:0]   i_io_sw,
   input  logic [KEY_W-1:0]  i_io_key,
   input  logic [31:0]       i_lsu_addr,
   input  logic              i_lsu_wren,
   input  logic [31:0]       i_st_data,
   output logic [31:0]       o_io_ld_data,
   output logic              o_io_hit
);

   localparam int              CNT_W   = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

   // Word addresses (byte address >> 2)
   localparam logic [29:0] ADDR_SW    = 30'h0000_0704;
   localparam logic [29:0] ADDR_KEY   = 30'h0000_0705;
   localparam logic [29:0] ADDR_EDGE  = 30'h0000_0706;
   localparam logic [29:0] ADDR_COUNT = 30'h0000_0707;

   logic [SW_W-1:0]  r_sw_s1, r_sw_s2;
   logic [KEY_W-1:0] r_key_s1, r_key_s2;
   logic [KEY_W-1:0] r_stable;
   logic [CNT_W-1:0] r_db_cnt [KEY_W];
   logic [KEY_W-1:0] r_edge;
   logic [31:0]      r_count;
   logic [31:0]      r_ld_data;
   logic             r_hit;

   logic [KEY_W-1:0] w_key_sync;
   logic [KEY_W-1:0] w_stable_d;
   logic [CNT_W-1:0] w_db_cnt_d [KEY_W];
   logic [KEY_W-1:0] w_press;
   logic [KEY_W-1:0] w_edge_d;
   logic [31:0]      w_count_d;
   logic [31:0]      w_ld_data_d;
   logic             w_hit_d;
   logic             w_sel_sw, w_sel_key, w_sel_edge, w_sel_count;
   logic             w_unused;

   assign w_sel_sw    = (i_lsu_addr[31:2] == ADDR_SW);
   assign w_sel_key   = (i_lsu_addr[31:2] == ADDR_KEY);
   assign w_sel_edge  = (i_lsu_addr[31:2] == ADDR_EDGE);
   assign w_sel_count = (i_lsu_addr[31:2] == ADDR_COUNT);
   assign w_hit_d     = w_sel_sw | w_sel_key | w_sel_edge | w_sel_count;

   // Keys are active-low on the pins; pressed = 1 from here on.
   assign w_key_sync = ~r_key_s2;

   // Byte offset and high store-data bits do not affect this block.
   assign w_unused = ^{i_lsu_addr[1:0], i_st_data};

   // Two-flop synchronizers; keys reset to released (pin high).
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_sw_s1  <= '0;
         r_sw_s2  <= '0;
         r_key_s1 <= '1;
         r_key_s2 <= '1;
      end else begin
         r_sw_s1  <= i_io_sw;
         r_sw_s2  <= r_sw_s1;
         r_key_s1 <= i_io_key;
         r_key_s2 <= r_key_s1;
      end
   end

   // Debounce next-state: accept a change after DEBOUNCE_CYCLES disagreeing cycles.
   always_comb begin
      w_stable_d = r_stable;
      w_press    = '0;
      for (int k = 0; k < KEY_W; k++) begin
         w_db_cnt_d[k] = '0;
         if (w_key_sync[k] != r_stable[k]) begin
            if (r_db_cnt[k] == CNT_MAX) begin
               w_stable_d[k] = w_key_sync[k];
               w_press[k]    = w_key_sync[k];
            end else begin
               w_db_cnt_d[k] = r_db_cnt[k] + CNT_W'(1);
            end
         end
      end
   end

   // Debounce state registers.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_stable <= '0;
         for (int k = 0; k < KEY_W; k++) begin
            r_db_cnt[k] <= '0;
         end
      end else begin
         r_stable <= w_stable_d;
         for (int k = 0; k < KEY_W; k++) begin
            r_db_cnt[k] <= w_db_cnt_d[k];
         end
      end
   end

   // Event next-state: a press set beats a same-cycle clear.
   always_comb begin
      w_edge_d = r_edge;
      if (i_lsu_wren && w_sel_edge) begin
         w_edge_d = r_edge & ~i_st_data[KEY_W-1:0];
      end
      w_edge_d = w_edge_d | w_press;

      w_count_d = r_count;
      if (i_lsu_wren && w_sel_count) begin
         w_count_d = {31'b0, w_press[0]};
      end else if (w_press[0]) begin
         w_count_d = r_count + 32'd1;
      end
   end

   // Event registers.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_edge  <= '0;
         r_count <= '0;
      end else begin
         r_edge  <= w_edge_d;
         r_count <= w_count_d;
      end
   end

   // Read mux on pre-write register values.
   always_comb begin
      w_ld_data_d = '0;
      if (w_sel_sw) begin
         w_ld_data_d = 32'(r_sw_s2);
      end else if (w_sel_key) begin
         w_ld_data_d = 32'(r_stable);
      end else if (w_sel_edge) begin
         w_ld_data_d = 32'(r_edge);
      end else if (w_sel_count) begin
         w_ld_data_d = r_count;
      end
   end

   // Registered load response, one cycle latency.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_ld_data <= '0;
         r_hit     <= 1'b0;
      end else begin
         r_ld_data <= w_ld_data_d;
         r_hit     <= w_hit_d;
      end
   end

   assign o_io_ld_data = r_ld_data;
   assign o_io_hit     = r_hit;

endmodule

// File: tb/tb_io_input_unit.sv
// tb_io_input_unit: directed test-plan steps followed by randomized traffic,
// all checked against a history-window reference model.
module tb_io_input_unit;

   localparam int SW_W  = 18;
   localparam int KEY_W = 4;
   localparam int DB    = 4;
   localparam int MAXN  = 4096;

   logic              i_clk = 1'b0;
   logic              i_rst;
   logic [SW_W-1:0]   i_io_sw;
   logic [KEY_W-1:0]  i_io_key;
   logic [31:0]       i_lsu_addr;
   logic              i_lsu_wren;
   logic [31:0]       i_st_data;
   logic [31:0]       o_io_ld_data;
   logic              o_io_hit;

   always #5 i_clk = ~i_clk;

   io_input_unit #(
      .SW_W           (SW_W),
      .KEY_W          (KEY_W),
      .DEBOUNCE_CYCLES(DB)
   ) dut (
      .i_clk       (i_clk),
      .i_rst       (i_rst),
      .i_io_sw     (i_io_sw),
      .i_io_key    (i_io_key),
      .i_lsu_addr  (i_lsu_addr),
      .i_lsu_wren  (i_lsu_wren),
      .i_st_data   (i_st_data),
      .o_io_ld_data(o_io_ld_data),
      .o_io_hit    (o_io_hit)
   );

   int n_total = 0;
   int n_pass  = 0;
   int n_fail  = 0;

   // Reference model: pin values sampled at each clock edge since reset release.
   logic [KEY_W-1:0] m_keyp [MAXN];
   logic [SW_W-1:0]  m_swp  [MAXN];
   int               m_n;
   logic [KEY_W-1:0] m_stable;
   logic [KEY_W-1:0] m_edge;
   logic [31:0]      m_count;
   logic [31:0]      m_ld;
   logic             m_hit;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_n      = 0;
      m_stable = '0;
      m_edge   = '0;
      m_count  = '0;
      m_ld     = '0;
      m_hit    = 1'b0;
   endtask

   // Synchronized (pressed-high) key value visible after edge j.
   function automatic logic [KEY_W-1:0] syn_key(input int j);
      return (j >= 2) ? ~m_keyp[j-1] : '0;
   endfunction

   function automatic logic [SW_W-1:0] syn_sw(input int j);
      return (j >= 2) ? m_swp[j-1] : '0;
   endfunction

   // Apply one clock edge to the model using the inputs present at that edge.
   task automatic model_edge();
      int               n;
      logic [KEY_W-1:0] press;
      logic [KEY_W-1:0] sk;
      logic [KEY_W-1:0] clr;
      bit               acc;
      n = m_n + 1;
      m_hit = (i_lsu_addr[31:4] == 28'h00001C1);
      m_ld  = '0;
      if (m_hit) begin
         case (i_lsu_addr[3:2])
            2'd0: m_ld = {{(32-SW_W){1'b0}}, syn_sw(n-1)};
            2'd1: m_ld = {{(32-KEY_W){1'b0}}, m_stable};
            2'd2: m_ld = {{(32-KEY_W){1'b0}}, m_edge};
            default: m_ld = m_count;
         endcase
      end
      // A key flips when the last DB synchronized samples all disagree with it.
      press = '0;
      for (int k = 0; k < KEY_W; k++) begin
         acc = (n >= DB);
         if (acc) begin
            for (int j = n - DB; j < n; j++) begin
               sk = syn_key(j);
               if (sk[k] == m_stable[k]) acc = 0;
            end
         end
         if (acc) begin
            m_stable[k] = ~m_stable[k];
            press[k]    = m_stable[k];
         end
      end
      clr = (i_lsu_wren && m_hit && i_lsu_addr[3:2] == 2'd2) ? i_st_data[KEY_W-1:0] : '0;
      m_edge = (m_edge & ~clr) | press;
      if (i_lsu_wren && m_hit && i_lsu_addr[3:2] == 2'd3) m_count = press[0] ? 32'd1 : 32'd0;
      else if (press[0]) m_count = m_count + 32'd1;
      m_keyp[n] = i_io_key;
      m_swp[n]  = i_io_sw;
      m_n       = n;
   endtask

   // One bus cycle: drive, clock, then compare registered outputs with the model.
   task automatic step(input logic [31:0] addr, input logic wren, input logic [31:0] data);
      i_lsu_addr = addr;
      i_lsu_wren = wren;
      i_st_data  = data;
      @(posedge i_clk);
      model_edge();
      #1;
      chk("model_hit", {31'b0, o_io_hit}, {31'b0, m_hit});
      chk("model_ld", o_io_ld_data, m_ld);
      i_lsu_wren = 1'b0;
   endtask

   task automatic idle(input int cycles);
      for (int i = 0; i < cycles; i++) step(32'h0, 1'b0, 32'h0);
   endtask

   task automatic load_chk(input string tag, input logic [31:0] addr, input logic [31:0] exp);
      step(addr, 1'b0, 32'h0);
      chk(tag, o_io_ld_data, exp);
   endtask

   initial begin
      i_rst      = 1'b1;
      i_io_sw    = '0;
      i_io_key   = '1;
      i_lsu_addr = '0;
      i_lsu_wren = 1'b0;
      i_st_data  = '0;
      model_reset();
      #1;
      chk("reset_ld", o_io_ld_data, 32'h0);
      chk("reset_hit", {31'b0, o_io_hit}, 32'h0);
      @(posedge i_clk);
      @(posedge i_clk);
      #1;
      i_rst = 1'b0;

      // Switch read
      i_io_sw = 18'h2A5A5;
      idle(3);
      load_chk("sw_read", 32'h1C12, 32'h0002A5A5);
      chk("sw_hit", {31'b0, o_io_hit}, 32'h1);

      // Short glitch is rejected
      i_io_key[0] = 1'b0;
      idle(3);
      i_io_key[0] = 1'b1;
      idle(6);
      load_chk("glitch_key", 32'h1C14, 32'h0);
      load_chk("glitch_edge", 32'h1C18, 32'h0);
      load_chk("glitch_count", 32'h1C1C, 32'h0);

      // Held press is accepted
      i_io_key[0] = 1'b0;
      idle(10);
      load_chk("press_key", 32'h1C14, 32'h1);
      load_chk("press_edge", 32'h1C18, 32'h1);
      load_chk("press_count", 32'h1C1C, 32'h1);

      // Release leaves EDGE set
      i_io_key[0] = 1'b1;
      idle(10);
      load_chk("release_key", 32'h1C14, 32'h0);
      load_chk("release_edge", 32'h1C18, 32'h1);

      // W1C clear, then clear racing a key-1 accept
      step(32'h1C18, 1'b1, 32'h1);
      load_chk("w1c_clear", 32'h1C18, 32'h0);
      i_io_key[1] = 1'b0;
      idle(5);
      step(32'h1C18, 1'b1, 32'h2);
      load_chk("w1c_race", 32'h1C18, 32'h2);
      i_io_key[1] = 1'b1;
      idle(10);
      step(32'h1C18, 1'b1, 32'hF);

      // Counter: five presses, then a clear racing a press accept
      step(32'h1C1C, 1'b1, 32'h0);
      for (int p = 0; p < 5; p++) begin
         i_io_key[0] = 1'b0;
         idle(8);
         i_io_key[0] = 1'b1;
         idle(8);
      end
      load_chk("count_five", 32'h1C1C, 32'h5);
      i_io_key[0] = 1'b0;
      idle(5);
      step(32'h1C1D, 1'b1, 32'hDEAD);
      load_chk("count_race", 32'h1C1C, 32'h1);
      i_io_key[0] = 1'b1;
      idle(8);

      // Unmapped and read-only
      load_chk("unmapped_ld", 32'h1C00, 32'h0);
      chk("unmapped_hit", {31'b0, o_io_hit}, 32'h0);
      step(32'h1C10, 1'b1, 32'hFFFFFFFF);
      load_chk("sw_readonly", 32'h1C10, 32'h0002A5A5);

      // Reset two cycles into a debounce with key 0 held
      i_io_key[0] = 1'b0;
      idle(3);
      step(32'h1C10, 1'b0, 32'h0);
      i_rst = 1'b1;
      #1;
      chk("midrst_ld", o_io_ld_data, 32'h0);
      chk("midrst_hit", {31'b0, o_io_hit}, 32'h0);
      model_reset();
      @(posedge i_clk);
      @(posedge i_clk);
      #1;
      i_rst = 1'b0;
      idle(6);
      load_chk("rerun_key", 32'h1C14, 32'h1);
      load_chk("rerun_edge", 32'h1C18, 32'h1);
      i_io_key = '1;
      idle(8);

      // Randomized traffic against the model
      for (int t = 0; t < 800; t++) begin
         logic [31:0] addr;
         logic        wr;
         for (int k = 0; k < KEY_W; k++) begin
            if ($urandom_range(0, 5) == 0) i_io_key[k] = ~i_io_key[k];
         end
         if ($urandom_range(0, 15) == 0) i_io_sw = SW_W'($urandom);
         case ($urandom_range(0, 5))
            0, 1, 2: addr = 32'h1C10 + 32'($urandom_range(0, 15));
            3:       addr = 32'h1C00 + 32'($urandom_range(0, 15));
            4:       addr = 32'h1C20 + 32'($urandom_range(0, 15));
            default: addr = $urandom;
         endcase
         wr = ($urandom_range(0, 3) == 0);
         step(addr, wr, $urandom);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
